// File: rtl/ft_cmd_decoder.sv
// Host command decoder: parses fixed-length write/read packets from the RX FIFO,
// issues single-cycle register-bus accesses and pushes one reply byte per command.
module ft_cmd_decoder #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_rdata,
    input  logic       rx_rempty,
    output logic       rx_rinc,
    output logic [7:0] tx_wdata,
    output logic       tx_winc,
    input  logic       tx_wfull,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       proto_err
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RPL_ACK = 8'h4B;
    localparam logic [7:0] RPL_ERR = 8'hEE;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXEC_WR,
        EXEC_RD,
        RD_WAIT,
        SEND
    } state_t;

    state_t           state, state_n;
    logic             is_rd, is_rd_n;
    logic [7:0]       addr_n, wdata_n, reply_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // State, captured fields and strobes; tx_wdata doubles as the reply register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            is_rd     <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            tx_wdata  <= 8'h00;
            cnt       <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            is_rd     <= is_rd_n;
            reg_addr  <= addr_n;
            reg_wdata <= wdata_n;
            tx_wdata  <= reply_n;
            cnt       <= cnt_n;
            reg_we    <= (state_n == EXEC_WR);
            reg_re    <= (state_n == EXEC_RD);
            busy      <= (state_n != IDLE);
        end
    end

    // Next state, FIFO handshakes and capture; pops happen in the cycle they are decided
    always_comb begin
        state_n   = state;
        is_rd_n   = is_rd;
        addr_n    = reg_addr;
        wdata_n   = reg_wdata;
        reply_n   = tx_wdata;
        cnt_n     = cnt;
        rx_rinc   = 1'b0;
        tx_winc   = 1'b0;
        proto_err = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_rempty) begin
                    rx_rinc = 1'b1;
                    if (rx_rdata == OP_WR || rx_rdata == OP_RD) begin
                        is_rd_n = (rx_rdata == OP_RD);
                        state_n = GET_ADDR;
                    end else begin
                        reply_n   = RPL_ERR;
                        proto_err = 1'b1;
                        state_n   = SEND;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                if (!rx_rempty) begin
                    rx_rinc = 1'b1;
                    cnt_n   = '0;
                    if (state == GET_ADDR) begin
                        addr_n  = rx_rdata;
                        state_n = is_rd ? EXEC_RD : GET_DATA;
                    end else begin
                        wdata_n = rx_rdata;
                        state_n = EXEC_WR;
                    end
                end else if (cnt >= CNT_LAST) begin
                    // Host stalled mid-packet: drop it silently apart from the error pulse
                    proto_err = 1'b1;
                    state_n   = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            EXEC_WR: begin
                reply_n = RPL_ACK;
                state_n = SEND;
            end
            EXEC_RD: state_n = RD_WAIT;
            RD_WAIT: begin
                reply_n = reg_rdata;
                state_n = SEND;
            end
            SEND: begin
                if (!tx_wfull) begin
                    tx_winc = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ft_cmd_decoder.sv
// Bench for ft_cmd_decoder: cycle-exact packet table, corner sequences and a random
// packet stream checked against a register-map model.
module tb_ft_cmd_decoder;
    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_rdata;
    logic       rx_rempty;
    logic       rx_rinc;
    logic [7:0] tx_wdata;
    logic       tx_winc;
    logic       tx_wfull;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       proto_err;

    ft_cmd_decoder #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_rdata(rx_rdata), .rx_rempty(rx_rempty), .rx_rinc(rx_rinc),
        .tx_wdata(tx_wdata), .tx_winc(tx_winc), .tx_wfull(tx_wfull),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // RX FIFO (fed by the test), TX FIFO sink and register-bus stub
    logic [7:0] rx_mem [4096];
    logic [7:0] tx_mem [4096];
    bit   [11:0] rx_wp, rx_rp, tx_wp;
    logic [7:0] regs [256];
    bit         written [256];
    bit         force_full, rand_full, rnd_full;
    int         we_cnt, re_cnt, err_cnt, rinc_viol, winc_viol;
    logic [7:0] last_wa, last_wd;

    assign rx_rempty = (rx_rp == rx_wp);
    assign rx_rdata  = rx_mem[rx_rp];
    assign tx_wfull  = force_full | (rand_full & rnd_full);

    always @(posedge clk) begin
        if (reg_we) begin
            regs[reg_addr]    <= reg_wdata;
            written[reg_addr] <= 1'b1;
            we_cnt  <= we_cnt + 1;
            last_wa <= reg_addr;
            last_wd <= reg_wdata;
        end
        reg_rdata <= reg_re ? (written[reg_addr] ? regs[reg_addr] : (reg_addr ^ 8'h1E)) : 8'h00;
        if (reg_re) re_cnt <= re_cnt + 1;
        if (proto_err) err_cnt <= err_cnt + 1;
        if (rx_rinc) begin
            rx_rp <= rx_rp + 12'd1;
            if (rx_rempty) rinc_viol <= rinc_viol + 1;
        end
        if (tx_winc) begin
            tx_mem[tx_wp] <= tx_wdata;
            tx_wp <= tx_wp + 12'd1;
            if (tx_wfull) winc_viol <= winc_viol + 1;
        end
        rnd_full <= ($urandom_range(0, 9) < 3);
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         len;
        int         kind;        // 0 write, 1 read, 2 bad opcode
        logic [7:0] reply, addr, wdata;
        logic [5:0] m_rinc, m_we, m_re, m_winc, m_err, m_busy;  // bit k = cycle k
    } vec_t;

    int         total, bad;
    logic [7:0] mdl [256];
    logic [7:0] exp_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[rx_wp] = b;
        rx_wp = rx_wp + 12'd1;
    endtask

    function automatic vec_t mk_wr(input logic [7:0] a, input logic [7:0] d);
        vec_t v;
        v = '{b0: 8'h57, b1: a, b2: d, len: 3, kind: 0, reply: 8'h4B, addr: a, wdata: d,
              m_rinc: 6'b000111, m_we: 6'b001000, m_re: 6'b000000,
              m_winc: 6'b010000, m_err: 6'b000000, m_busy: 6'b011110};
        return v;
    endfunction

    function automatic vec_t mk_rd(input logic [7:0] a, input logic [7:0] r);
        vec_t v;
        v = '{b0: 8'h52, b1: a, b2: 8'h00, len: 2, kind: 1, reply: r, addr: a, wdata: 8'h00,
              m_rinc: 6'b000011, m_we: 6'b000000, m_re: 6'b000100,
              m_winc: 6'b010000, m_err: 6'b000000, m_busy: 6'b011110};
        return v;
    endfunction

    function automatic vec_t mk_bad(input logic [7:0] op);
        vec_t v;
        v = '{b0: op, b1: 8'h00, b2: 8'h00, len: 1, kind: 2, reply: 8'hEE, addr: 8'h00, wdata: 8'h00,
              m_rinc: 6'b000001, m_we: 6'b000000, m_re: 6'b000000,
              m_winc: 6'b000010, m_err: 6'b000001, m_busy: 6'b000010};
        return v;
    endfunction

    // Preload one packet, then record six cycles of strobes and compare against the masks
    task automatic run_vec(input vec_t v, input string nm);
        logic [5:0] s_rinc, s_we, s_re, s_winc, s_err, s_busy;
        bit [11:0]  wp0;
        @(negedge clk);
        wp0 = tx_wp;
        push(v.b0);
        if (v.len > 1) push(v.b1);
        if (v.len > 2) push(v.b2);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            s_rinc[k] = rx_rinc; s_we[k] = reg_we; s_re[k] = reg_re;
            s_winc[k] = tx_winc; s_err[k] = proto_err; s_busy[k] = busy;
        end
        check({nm, "_rinc"}, 32'(s_rinc), 32'(v.m_rinc));
        check({nm, "_we"},   32'(s_we),   32'(v.m_we));
        check({nm, "_re"},   32'(s_re),   32'(v.m_re));
        check({nm, "_winc"}, 32'(s_winc), 32'(v.m_winc));
        check({nm, "_err"},  32'(s_err),  32'(v.m_err));
        check({nm, "_busy"}, 32'(s_busy), 32'(v.m_busy));
        check({nm, "_txcnt"}, 32'(tx_wp - wp0), 32'd1);
        check({nm, "_reply"}, 32'(tx_mem[wp0]), 32'(v.reply));
        if (v.kind != 2) check({nm, "_addr"}, 32'(reg_addr), 32'(v.addr));
        if (v.kind == 0) begin
            check({nm, "_wr"}, {16'h0, last_wa, last_wd}, {16'h0, v.addr, v.wdata});
            mdl[v.addr] = v.wdata;
        end
    endtask

    task automatic wait_tx(input bit [11:0] target, input string nm);
        int n = 0;
        while (tx_wp != target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(tx_wp), 32'(target));
    endtask

    vec_t vecs [11];

    initial begin
        int first, n_w, n_r, e0, w0, k;
        bit [11:0] wp0, rp0;
        logic [7:0] a, d, op;

        for (int i = 0; i < 256; i++) mdl[i] = 8'(i) ^ 8'h1E;
        vecs[0]  = mk_wr(8'h10, 8'hA5);
        vecs[1]  = mk_rd(8'h22, 8'h3C);
        vecs[2]  = mk_bad(8'h13);
        vecs[3]  = mk_rd(8'h05, 8'h1B);
        vecs[4]  = mk_rd(8'h10, 8'hA5);
        vecs[5]  = mk_wr(8'hFF, 8'h00);
        vecs[6]  = mk_rd(8'hFF, 8'h00);
        vecs[7]  = mk_bad(8'h00);
        vecs[8]  = mk_wr(8'h57, 8'h52);
        vecs[9]  = mk_rd(8'h57, 8'h52);
        vecs[10] = mk_bad(8'hFF);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {3'b0, rx_rinc, tx_winc, reg_we, reg_re, busy, proto_err, tx_wdata, reg_addr, reg_wdata},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Inter-byte timeout aborts the packet without any access or reply
        @(negedge clk);
        e0 = err_cnt; w0 = we_cnt; wp0 = tx_wp; first = -1;
        push(8'h57); push(8'h10);
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (proto_err && first < 0) first = c;
        end
        check("timeout_cycle_window", 32'(first >= int'(TO) && first <= int'(TO) + 2), 32'd1);
        check("timeout_err_once", 32'(err_cnt - e0), 32'd1);
        check("timeout_no_we", 32'(we_cnt - w0), 32'd0);
        check("timeout_no_tx", 32'(tx_wp - wp0), 32'd0);
        check("timeout_idle", 32'(busy), 32'd0);
        run_vec(mk_rd(8'h10, 8'hA5), "after_timeout");

        // TX full stalls SEND; next opcode stays queued until the reply goes out
        @(negedge clk);
        force_full = 1'b1;
        wp0 = tx_wp;
        push(8'h57); push(8'h20); push(8'h77); push(8'h52); push(8'h20);
        repeat (8) @(negedge clk);
        rp0 = rx_rp; n_w = 0; n_r = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            n_w += int'(tx_winc);
            n_r += int'(rx_rinc);
        end
        check("stall_no_winc", 32'(n_w), 32'd0);
        check("stall_no_rinc", 32'(n_r), 32'd0);
        check("stall_no_pop", 32'(rx_rp), 32'(rp0));
        check("stall_busy", 32'(busy), 32'd1);
        @(negedge clk);
        force_full = 1'b0;
        #1;
        check("stall_release_push", {23'h0, tx_winc, tx_wdata}, {23'h0, 1'b1, 8'h4B});
        mdl[8'h20] = 8'h77;
        wait_tx(wp0 + 12'd2, "stall_followup_done");
        check("stall_followup_reply", 32'(tx_mem[wp0 + 12'd1]), 32'h77);

        // Reset mid-packet, after opcode and address have been popped
        repeat (6) @(negedge clk);
        w0 = we_cnt;
        push(8'h57); push(8'h10);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {3'b0, rx_rinc, tx_winc, reg_we, reg_re, busy, proto_err, tx_wdata, reg_addr, reg_wdata},
              32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_no_we", 32'(we_cnt - w0), 32'd0);
        run_vec(mk_wr(8'h01, 8'hFF), "after_reset");

        // Random packet stream with random TX back-pressure against the register model
        @(negedge clk);
        rand_full = 1'b1;
        wp0 = tx_wp; e0 = err_cnt; w0 = we_cnt;
        n_w = 0; n_r = 0;
        exp_q.delete();
        for (int p = 0; p < 150; p++) begin
            k = $urandom_range(0, 9);
            a = 8'($urandom_range(0, 31));
            d = 8'($urandom_range(0, 255));
            if (k < 4) begin
                push(8'h57);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push(a);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push(d);
                mdl[a] = d;
                exp_q.push_back(8'h4B);
                n_w++;
            end else if (k < 8) begin
                push(8'h52);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push(a);
                exp_q.push_back(mdl[a]);
            end else begin
                do op = 8'($urandom_range(0, 255)); while (op == 8'h57 || op == 8'h52);
                push(op);
                exp_q.push_back(8'hEE);
                n_r++;
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_tx(wp0 + 12'(exp_q.size()), "rand_all_replies");
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_reply%0d", i), 32'(tx_mem[wp0 + 12'(i)]), 32'(exp_q[i]));
        check("rand_writes", 32'(we_cnt - w0), 32'(n_w));
        check("rand_errs", 32'(err_cnt - e0), 32'(n_r));
        check("rand_rx_drained", 32'(rx_rp), 32'(rx_wp));
        rand_full = 1'b0;
        repeat (5) @(negedge clk);
        check("rinc_when_empty", 32'(rinc_viol), 32'd0);
        check("winc_when_full", 32'(winc_viol), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
